// File: rtl/axi_stream_output_pkg.sv
// Shared defaults and FSM state type for the AXI-Stream output stage.
package axi_stream_output_pkg;

  localparam int unsigned N_DEF        = 8;
  localparam int unsigned CHAR_LEN_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_stream_output.sv
// Captures an N-character vector and serialises it as N AXI-Stream beats with TLAST on the last.
// Define AXIS_OUT_DOUBLE_BUF_EN to add a pending vector register for bubble-free back-to-back streams.
module axi_stream_output
  import axi_stream_output_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned CHAR_LEN = CHAR_LEN_DEF
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  valid,
  input  logic [N*CHAR_LEN-1:0] d,
  output logic                  ready,
  output logic                  done,
  output logic [CHAR_LEN-1:0]   M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                state_q, state_n;
  logic [N*CHAR_LEN-1:0] data_q, data_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic                  done_q, done_n;
  logic                  tlast_q, tlast_n;
  logic                  accept, hs, last;

`ifdef AXIS_OUT_DOUBLE_BUF_EN
  logic [N*CHAR_LEN-1:0] pend_q, pend_n;
  logic                  pend_full_q, pend_full_n;

  assign ready = !pend_full_q;
`else
  assign ready = (state_q == IDLE);
`endif

  assign accept        = valid && ready;
  assign hs            = M_AXIS_TVALID && M_AXIS_TREADY;
  assign last          = (cnt_q == LAST);
  assign M_AXIS_TVALID = (state_q == SEND);
  assign M_AXIS_TDATA  = data_q[CHAR_LEN-1:0];
  assign M_AXIS_TLAST  = tlast_q;
  assign done          = done_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
`ifdef AXIS_OUT_DOUBLE_BUF_EN
    pend_n      = pend_q;
    pend_full_n = pend_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_n  = d;
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (last) begin
            done_n = 1'b1;
`ifdef AXIS_OUT_DOUBLE_BUF_EN
            // Refill from pending first; a vector arriving on this edge only
            // reaches buf directly when pending was empty.
            if (pend_full_q) begin
              data_n      = pend_q;
              cnt_n       = '0;
              pend_full_n = 1'b0;
            end else if (accept) begin
              data_n = d;
              cnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
`else
            state_n = IDLE;
`endif
          end else begin
            data_n = data_q >> CHAR_LEN;
            cnt_n  = cnt_q + CW'(1);
          end
        end
`ifdef AXIS_OUT_DOUBLE_BUF_EN
        if (accept && !(hs && last)) begin
          pend_n      = d;
          pend_full_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    tlast_n = (state_n == SEND) && (cnt_n == LAST);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tlast_q <= 1'b0;
    end else begin
      data_q  <= data_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
      tlast_q <= tlast_n;
    end
  end

`ifdef AXIS_OUT_DOUBLE_BUF_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      pend_q      <= pend_n;
      pend_full_q <= pend_full_n;
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_output.sv
// Self-checking bench for axi_stream_output against a queue-based model of the stream.
// Double-buffer checks are selected by AXIS_OUT_DOUBLE_BUF_EN, matching the RTL build.
module tb_axi_stream_output;

  localparam int unsigned N  = 4;
  localparam int unsigned CL = 8;

  logic            ACLK, ARESETN, valid, ready, done;
  logic [N*CL-1:0] d;
  logic [CL-1:0]   tdata;
  logic            tlast, tvalid, tready;

  axi_stream_output #(.N(N), .CHAR_LEN(CL)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .valid(valid), .d(d), .ready(ready), .done(done),
    .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(tready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: characters still to be sent, plus at most one waiting vector.
  logic [CL-1:0]   cur[$];
  logic [N*CL-1:0] pend;
  bit              pend_v = 1'b0;
  bit              m_done = 1'b0;
  bit              m_acc, m_hs;

  function automatic bit m_ready();
`ifdef AXIS_OUT_DOUBLE_BUF_EN
    return !pend_v;
`else
    return cur.size() == 0;
`endif
  endfunction

  task automatic m_load(input logic [N*CL-1:0] v);
    cur.delete();
    for (int i = 0; i < int'(N); i++) cur.push_back(v[i*CL +: CL]);
  endtask

  always @(posedge ACLK or negedge ARESETN) begin
    cyc++;
    if (!ARESETN) begin
      cur.delete();
      pend_v = 1'b0;
      m_done = 1'b0;
    end else begin
      m_acc  = valid && m_ready();
      m_hs   = (cur.size() > 0) && tready;
      m_done = m_hs && (cur.size() == 1);
      if (m_hs) void'(cur.pop_front());
`ifdef AXIS_OUT_DOUBLE_BUF_EN
      if (cur.size() == 0 && pend_v) begin
        m_load(pend);
        pend_v = 1'b0;
      end
      if (m_acc) begin
        if (cur.size() == 0) m_load(d);
        else begin
          pend   = d;
          pend_v = 1'b1;
        end
      end
`else
      if (m_acc) m_load(d);
`endif
    end
  end

  // Monitor and per-cycle compare.
  logic [CL:0]   beats[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  bit            prev_stall = 1'b0;
  logic [CL-1:0] prev_data;
  logic          prev_last;

  always @(negedge ACLK) begin
    chk("ready", ready, m_ready());
    chk("tvalid", tvalid, cur.size() != 0);
    chk("tlast", tlast, cur.size() == 1);
    chk("done", done, m_done);
    if (cur.size() != 0) chk("tdata", tdata, cur[0]);
    if (prev_stall && ARESETN) begin
      chk("stall_tvalid", tvalid, 1'b1);
      chk("stall_tdata", tdata, prev_data);
      chk("stall_tlast", tlast, prev_last);
    end
    prev_stall = ARESETN && tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
    if (ARESETN && tvalid && tready) beats.push_back({tlast, tdata});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Present v until it is taken; returns the cycle number of the capture edge.
  task automatic send_vec(input logic [N*CL-1:0] v, output int cap);
    bit r = 1'b0;
    valid = 1'b1;
    d     = v;
    for (int k = 0; k < 50 && !r; k++) begin
      @(negedge ACLK);
      r = ready;
      @(posedge ACLK);
    end
    #1;
    cap   = cyc;
    valid = 1'b0;
    if (!r) chk("capture_timeout", 0, 1);
  endtask

  task automatic wait_dones(input int target);
    int k = 0;
    while (done_cnt < target && k < 200) begin
      @(negedge ACLK);
      #1;
      k++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  logic [N*CL-1:0] va, vb;
  logic [CL:0]     bt;
  int              cap, dc0;
  bit              pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    ARESETN = 1'b0;
    valid   = 1'b0;
    d       = '0;
    tready  = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tdata", tdata, '0);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    // Basic stream: characters 1..N, TREADY high.
    tready = 1'b1;
    for (int i = 0; i < int'(N); i++) va[i*CL +: CL] = CL'(i + 1);
    beats.delete();
    dc0 = done_cnt;
    send_vec(va, cap);
    wait_dones(dc0 + 1);
    chk("basic_latency", done_cyc - cap, N);
    chk("basic_count", beats.size(), N);
    for (int i = 0; i < int'(N) && i < beats.size(); i++) begin
      bt = beats[i];
      chk("basic_data", bt[CL-1:0], CL'(i + 1));
      chk("basic_last", bt[CL], i == int'(N) - 1);
    end
    chk("basic_first_lit", beats.size() > 0 ? beats[0] : '1, 9'h001);

    // Backpressure: 0x10 everywhere except 0xee last, TREADY pattern 1,0,0,1.
    repeat (2) @(posedge ACLK);
    #1;
    for (int i = 0; i < int'(N); i++) va[i*CL +: CL] = (i == int'(N) - 1) ? 8'hee : 8'h10;
    beats.delete();
    dc0 = done_cnt;
    send_vec(va, cap);
    for (int k = 0; k < 100 && done_cnt == dc0; k++) begin
      tready = pat[k % 4];
      @(negedge ACLK);
      #1;
      if (done_cnt == dc0) @(posedge ACLK);
      #1;
    end
    tready = 1'b1;
    chk("bp_done", done_cnt, dc0 + 1);
    chk("bp_count", beats.size(), N);
    for (int i = 0; i < int'(N) && i < beats.size(); i++) begin
      bt = beats[i];
      chk("bp_data", bt, {i == int'(N) - 1, (i == int'(N) - 1) ? 8'hee : 8'h10});
    end

`ifndef AXIS_OUT_DOUBLE_BUF_EN
    // Busy input: a second vector during SEND is ignored.
    repeat (2) @(posedge ACLK);
    #1;
    for (int i = 0; i < int'(N); i++) va[i*CL +: CL] = CL'(8'h30 + i);
    vb = '1;
    beats.delete();
    dc0 = done_cnt;
    send_vec(va, cap);
    valid = 1'b1;
    d     = vb;
    repeat (2) @(posedge ACLK);
    #1;
    valid = 1'b0;
    wait_dones(dc0 + 1);
    repeat (4) @(posedge ACLK);
    #1;
    chk("busy_count", beats.size(), N);
    chk("busy_dones", done_cnt, dc0 + 1);
    for (int i = 0; i < int'(N) && i < beats.size(); i++) begin
      bt = beats[i];
      chk("busy_data", bt[CL-1:0], CL'(8'h30 + i));
    end
`endif

    // Reset mid-stream after beat 3.
    repeat (2) @(posedge ACLK);
    #1;
    for (int i = 0; i < int'(N); i++) va[i*CL +: CL] = CL'(8'h50 + i);
    beats.delete();
    dc0 = done_cnt;
    send_vec(va, cap);
    for (int k = 0; k < 50 && beats.size() < 3; k++) begin
      @(negedge ACLK);
      #1;
    end
    chk("mid_beats", beats.size(), 3);
    @(posedge ACLK);
    #2;
    ARESETN = 1'b0;
    #1;
    chk("mid_tvalid_async", tvalid, 1'b0);
    chk("mid_tlast_async", tlast, 1'b0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("mid_no_done", done_cnt, dc0);
    for (int i = 0; i < int'(N); i++) vb[i*CL +: CL] = CL'(8'h70 + i);
    beats.delete();
    send_vec(vb, cap);
    wait_dones(dc0 + 1);
    chk("mid_restart_count", beats.size(), N);
    chk("mid_restart_first", beats.size() > 0 ? beats[0] : '1, 9'h070);

`ifdef AXIS_OUT_DOUBLE_BUF_EN
    // Back-to-back vectors stream with no bubble.
    repeat (2) @(posedge ACLK);
    #1;
    for (int i = 0; i < int'(N); i++) begin
      va[i*CL +: CL] = 8'h01;
      vb[i*CL +: CL] = 8'hff;
    end
    beats.delete();
    dc0   = done_cnt;
    valid = 1'b1;
    d     = va;
    @(posedge ACLK);
    #1;
    cap = cyc;
    d   = vb;
    @(posedge ACLK);
    #1;
    valid = 1'b0;
    wait_dones(dc0 + 2);
    chk("db_count", beats.size(), 2 * N);
    chk("db_dones", done_cnt, dc0 + 2);
    chk("db_span", done_cyc - cap, 2 * N);
    for (int i = 0; i < 2 * int'(N) && i < beats.size(); i++) begin
      bt = beats[i];
      chk("db_data", bt[CL-1:0], (i < int'(N)) ? 8'h01 : 8'hff);
      chk("db_last", bt[CL], (i == int'(N) - 1) || (i == 2 * int'(N) - 1));
    end
`endif

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      @(posedge ACLK);
      #1;
      valid  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < int'(N); i++) d[i*CL +: CL] = CL'($urandom);
      tready = ($urandom_range(0, 3) != 0);
    end
    valid  = 1'b0;
    tready = 1'b1;
    repeat (3 * N + 4) @(posedge ACLK);
    @(negedge ACLK);
    #1;
    chk("drain_idle", tvalid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
